id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register of the PL_CPU. Feeds the EX-stage operand multiplexer.
//  - w0 = register operand B, w1 = immediate, s = use_imm, flag = bubble.
//  - Detects load-use hazards, inserts bubbles, and honours downstream stall and flush.
//  - Counts inserted bubbles for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 102 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands/controls for EX, inserts
// bubbles on load-use hazards and flushes, honours EX stalls, counts bubbles.
module id_ex_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_op_a,
    input  logic [DATA_W-1:0] id_op_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic              ex_flag,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_w0,
    output logic [DATA_W-1:0] ex_w1,
    output logic              ex_sel,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;
    logic   haz, bubble, load;

    assign haz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0)
               & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Flush beats stall beats hazard; a flush also frees ID since the slot is squashed.
    assign bubble   = flush | (~ex_stall & haz);
    assign load     = ~flush & ~ex_stall & ~haz;
    assign id_stall = (ex_stall & ~flush) | (haz & ~flush & ~ex_stall);

    always_comb begin
        state_nxt = state;
        if (bubble)
            state_nxt = EMPTY;
        else if (load)
            state_nxt = id_valid ? FULL : EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    assign ex_valid = (state == FULL);
    assign ex_flag  = ~ex_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op_a      <= '0;
            ex_w0        <= '0;
            ex_w1        <= '0;
            ex_rd        <= '0;
            ex_sel       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (bubble) begin
            ex_op_a      <= '0;
            ex_w0        <= '0;
            ex_w1        <= '0;
            ex_rd        <= '0;
            ex_sel       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (load) begin
            // Data is captured even for an invalid slot; only controls are gated.
            ex_op_a      <= id_op_a;
            ex_w0        <= id_op_b;
            ex_w1        <= id_imm;
            ex_rd        <= id_rd;
            ex_sel       <= id_valid & id_use_imm;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_reg_write <= id_valid & id_reg_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_count <= '0;
        else if (bubble && (bubble_count != '1))
            bubble_count <= bubble_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a randomized
// run against a transaction-level model of the EX slot.
module tb_id_ex_pipe_reg;

    localparam int DW = 64;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic          id_valid, id_use_imm, id_mem_read, id_reg_write, flush, ex_stall;
    logic [DW-1:0] id_op_a, id_op_b, id_imm;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;

    logic          ex_valid, ex_flag, ex_sel, ex_mem_read, ex_reg_write, id_stall;
    logic [DW-1:0] ex_op_a, ex_w0, ex_w1;
    logic [AW-1:0] ex_rd;
    logic [15:0]   bubble_count;

    logic          b_valid, b_flag, b_sel, b_mr, b_rw, b_stall;
    logic [DW-1:0] b_op_a, b_w0, b_w1;
    logic [AW-1:0] b_rd;
    logic [1:0]    b_count;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_a(id_op_a), .id_op_b(id_op_b),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_flag(ex_flag),
        .ex_op_a(ex_op_a), .ex_w0(ex_w0), .ex_w1(ex_w1), .ex_sel(ex_sel), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .id_stall(id_stall),
        .bubble_count(bubble_count));

    id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_a(id_op_a), .id_op_b(id_op_b),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .flush(flush), .ex_stall(ex_stall), .ex_valid(b_valid), .ex_flag(b_flag),
        .ex_op_a(b_op_a), .ex_w0(b_w0), .ex_w1(b_w1), .ex_sel(b_sel), .ex_rd(b_rd),
        .ex_mem_read(b_mr), .ex_reg_write(b_rw), .id_stall(b_stall),
        .bubble_count(b_count));

    // Model of what sits in EX, as an instruction record.
    typedef struct {
        bit            valid;
        logic [DW-1:0] a, b, imm;
        bit            sel, mr, rw;
        logic [AW-1:0] rd;
    } slot_t;

    slot_t m;
    int    m_cnt;
    int    n_cmp, n_bad;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.a = '0; s.b = '0; s.imm = '0;
        s.sel = 0; s.mr = 0; s.rw = 0; s.rd = '0;
        return s;
    endfunction

    function automatic bit m_haz();
        return id_valid && m.valid && m.mr && (m.rd != 0) && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    function automatic bit m_stall();
        if (flush) return 0;
        if (ex_stall) return 1;
        return m_haz();
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    endfunction

    // One clock edge: advance the model by the per-edge priority rules.
    task automatic cycle();
        bit h;
        h = m_haz();
        @(posedge clk);
        if (flush) begin
            m = empty_slot(); m_cnt++;
        end else if (ex_stall) begin
            // slot unchanged
        end else if (h) begin
            m = empty_slot(); m_cnt++;
        end else begin
            m.valid = id_valid; m.a = id_op_a; m.b = id_op_b; m.imm = id_imm; m.rd = id_rd;
            m.sel = id_valid && id_use_imm; m.mr = id_valid && id_mem_read;
            m.rw = id_valid && id_reg_write;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_op_a = '0; id_op_b = '0; id_imm = '0; id_use_imm = 0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_mem_read = 0; id_reg_write = 0;
        flush = 0; ex_stall = 0;
    endtask

    task automatic set_instr(input logic [DW-1:0] b, input logic [DW-1:0] imm,
                             input bit ui, input int rs1, input int rs2, input int rd,
                             input bit mr);
        id_valid = 1; id_op_a = {$urandom, $urandom}; id_op_b = b; id_imm = imm;
        id_use_imm = ui; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
        id_mem_read = mr; id_reg_write = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_instr(64'h55, 64'h66, 1, 1, 2, 7, 1);
        cycle();
        #2 rst = 1;
        #1;
        m = empty_slot(); m_cnt = 0;
        n_cmp++;
        if ({ex_valid, ex_flag, ex_sel, ex_mem_read, ex_reg_write} !== 5'b01000 ||
            ex_op_a !== '0 || ex_w0 !== '0 || ex_w1 !== '0 || ex_rd !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b flag=%b sel=%b mr=%b rw=%b rd=%0d w0=%h, required 0/1/0/0/0/0/0",
                     ex_valid, ex_flag, ex_sel, ex_mem_read, ex_reg_write, ex_rd, ex_w0);
        end
        n_cmp++;
        if (bubble_count !== 16'd0 || b_count !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d/%0d, required 0/0", bubble_count, b_count);
        end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        #1;
    endtask

    task automatic test_load();
        set_instr(64'h11, 64'h22, 1, 1, 2, 3, 0);
        cycle();
        n_cmp++;
        if (ex_w0 !== 64'h11 || ex_w1 !== 64'h22 || ex_sel !== 1 || ex_valid !== 1 ||
            ex_flag !== 0 || ex_rd !== 5'd3 || ex_op_a !== m.a) begin
            n_bad++;
            $display("FAIL load_basic: got w0=%h w1=%h sel=%b valid=%b flag=%b rd=%0d, required 11/22/1/1/0/3",
                     ex_w0, ex_w1, ex_sel, ex_valid, ex_flag, ex_rd);
        end
        // invalid slot: data captured, controls zeroed
        set_instr(64'h77, 64'h88, 1, 1, 2, 9, 1);
        id_valid = 0;
        cycle();
        n_cmp++;
        if (ex_valid !== 0 || ex_flag !== 1 || ex_sel !== 0 || ex_mem_read !== 0 ||
            ex_reg_write !== 0 || ex_w0 !== 64'h77 || ex_w1 !== 64'h88 || ex_rd !== 5'd9) begin
            n_bad++;
            $display("FAIL load_invalid: got valid=%b sel=%b mr=%b rw=%b w0=%h rd=%0d, required 0/0/0/0/77/9",
                     ex_valid, ex_sel, ex_mem_read, ex_reg_write, ex_w0, ex_rd);
        end
    endtask

    task automatic test_hazard();
        int c0;
        logic [DW-1:0] dep_b;
        set_instr(64'h1234, 64'h0, 0, 1, 2, 5, 1);
        cycle();
        c0 = m_cnt;
        dep_b = 64'hABCD;
        set_instr(dep_b, 64'h4, 0, 6, 5, 8, 0);
        #1;
        n_cmp++;
        if (id_stall !== 1) begin
            n_bad++;
            $display("FAIL hazard_stall: got id_stall=%b, required 1", id_stall);
        end
        cycle();
        n_cmp++;
        if (ex_flag !== 1 || ex_valid !== 0 || bubble_count !== 16'(c0 + 1)) begin
            n_bad++;
            $display("FAIL hazard_bubble: got flag=%b valid=%b count=%0d, required 1/0/%0d",
                     ex_flag, ex_valid, bubble_count, c0 + 1);
        end
        n_cmp++;
        if (id_stall !== 0) begin
            n_bad++;
            $display("FAIL hazard_release: got id_stall=%b, required 0", id_stall);
        end
        cycle();
        n_cmp++;
        if (ex_valid !== 1 || ex_w0 !== dep_b || ex_rd !== 5'd8) begin
            n_bad++;
            $display("FAIL hazard_enter: got valid=%b w0=%h rd=%0d, required 1/%h/8",
                     ex_valid, ex_w0, ex_rd, dep_b);
        end
    endtask

    task automatic test_rd_zero();
        int c0;
        set_instr(64'h1, 64'h2, 0, 3, 4, 0, 1);
        cycle();
        c0 = m_cnt;
        set_instr(64'h3, 64'h4, 0, 0, 0, 6, 0);
        #1;
        n_cmp++;
        if (id_stall !== 0) begin
            n_bad++;
            $display("FAIL rd0_nostall: got id_stall=%b, required 0", id_stall);
        end
        cycle();
        n_cmp++;
        if (ex_valid !== 1 || ex_rd !== 5'd6 || bubble_count !== 16'(c0)) begin
            n_bad++;
            $display("FAIL rd0_pass: got valid=%b rd=%0d count=%0d, required 1/6/%0d",
                     ex_valid, ex_rd, bubble_count, c0);
        end
    endtask

    task automatic test_stall_flush();
        int c0;
        logic [DW-1:0] b0;
        b0 = {$urandom, $urandom};
        set_instr(b0, 64'h99, 1, 1, 2, 12, 1);
        cycle();
        c0 = m_cnt;
        ex_stall = 1;
        set_instr(64'hDEAD, 64'hBEEF, 0, 1, 2, 13, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (id_stall !== 1) begin
                n_bad++;
                $display("FAIL stall_idstall[%0d]: got %b, required 1", i, id_stall);
            end
            cycle();
            n_cmp++;
            if (ex_w0 !== b0 || ex_w1 !== 64'h99 || ex_rd !== 5'd12 || ex_valid !== 1 ||
                ex_sel !== 1 || ex_mem_read !== 1 || bubble_count !== 16'(c0)) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got w0=%h rd=%0d valid=%b count=%0d, required %h/12/1/%0d",
                         i, ex_w0, ex_rd, ex_valid, bubble_count, b0, c0);
            end
        end
        flush = 1;
        #1;
        n_cmp++;
        if (id_stall !== 0) begin
            n_bad++;
            $display("FAIL flush_idstall: got %b, required 0", id_stall);
        end
        cycle();
        n_cmp++;
        if (ex_flag !== 1 || ex_valid !== 0 || ex_w0 !== '0 || ex_rd !== '0 ||
            bubble_count !== 16'(c0 + 1)) begin
            n_bad++;
            $display("FAIL flush_bubble: got flag=%b w0=%h rd=%0d count=%0d, required 1/0/0/%0d",
                     ex_flag, ex_w0, ex_rd, bubble_count, c0 + 1);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        idle_inputs();
        flush = 1;
        for (int i = 0; i < 5; i++) cycle();
        flush = 0;
        n_cmp++;
        if (b_count !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_cnt2: got %0d, required 3", b_count);
        end
        n_cmp++;
        if (bubble_count !== exp_cnt16()) begin
            n_bad++;
            $display("FAIL sat_cnt16: got %0d, required %0d", bubble_count, exp_cnt16());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_op_a      = {$urandom, $urandom};
            id_op_b      = {$urandom, $urandom};
            id_imm       = {$urandom, $urandom};
            id_use_imm   = $urandom_range(0, 1);
            id_rs1       = AW'($urandom_range(0, 3));
            id_rs2       = AW'($urandom_range(0, 3));
            id_rd        = AW'($urandom_range(0, 3));
            id_mem_read  = $urandom_range(0, 1);
            id_reg_write = $urandom_range(0, 1);
            flush        = ($urandom_range(0, 9) == 0);
            ex_stall     = ($urandom_range(0, 4) == 0);
            #1;
            n_cmp++;
            if (id_stall !== m_stall() || b_stall !== m_stall()) begin
                n_bad++;
                $display("FAIL rand_idstall[%0d]: got %b/%b, required %b", i, id_stall, b_stall, m_stall());
            end
            cycle();
            n_cmp++;
            if (ex_valid !== m.valid || ex_flag !== !m.valid || ex_op_a !== m.a ||
                ex_w0 !== m.b || ex_w1 !== m.imm || ex_sel !== m.sel || ex_rd !== m.rd ||
                ex_mem_read !== m.mr || ex_reg_write !== m.rw ||
                bubble_count !== exp_cnt16() || b_count !== exp_cnt2()) begin
                n_bad++;
                $display("FAIL rand_ex[%0d]: got v=%b f=%b sel=%b rd=%0d mr=%b rw=%b w0=%h cnt=%0d/%0d, required v=%b sel=%b rd=%0d mr=%b rw=%b w0=%h cnt=%0d/%0d",
                         i, ex_valid, ex_flag, ex_sel, ex_rd, ex_mem_read, ex_reg_write, ex_w0,
                         bubble_count, b_count, m.valid, m.sel, m.rd, m.mr, m.rw, m.b,
                         exp_cnt16(), exp_cnt2());
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m = empty_slot(); m_cnt = 0;
        idle_inputs();
        rst = 1;
        #12 rst = 0;
        #1;
        test_reset();
        test_load();
        test_hazard();
        test_rd_zero();
        test_stall_flush();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
